// File: rtl/wb_irq_ctrl_if.sv
// Wishbone B3 classic bus port of wb_irq_ctrl; signal names are from the slave's point of view.
interface wb_irq_ctrl_if;
    logic [4:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport slave (
        input  wb_adr_i,
        input  wb_dat_i,
        input  wb_sel_i,
        input  wb_we_i,
        input  wb_cyc_i,
        input  wb_stb_i,
        output wb_dat_o,
        output wb_ack_o,
        output wb_err_o
    );

    modport master (
        output wb_adr_i,
        output wb_dat_i,
        output wb_sel_i,
        output wb_we_i,
        output wb_cyc_i,
        output wb_stb_i,
        input  wb_dat_o,
        input  wb_ack_o,
        input  wb_err_o
    );
endinterface

// File: rtl/wb_irq_ctrl.sv
// Wishbone interrupt controller: per-channel synchroniser, level/edge mode, polarity,
// sticky pending and mask, driving the CPU interrupt vector.
module wb_irq_ctrl #(
    parameter int unsigned NUM_IRQ     = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    wb_irq_ctrl_if.slave       wb,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    output logic [NUM_IRQ-1:0] irq_o,
    output logic               irq_any_o
);

    localparam logic [2:0] RegPending  = 3'd0;
    localparam logic [2:0] RegMask     = 3'd1;
    localparam logic [2:0] RegMode     = 3'd2;
    localparam logic [2:0] RegPolarity = 3'd3;
    localparam logic [2:0] RegActive   = 3'd4;
    localparam logic [2:0] RegSwset    = 3'd5;

    logic [NUM_IRQ-1:0] src_sync;
    logic [NUM_IRQ-1:0] src_d_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mode_q, pol_q;
    logic [31:0]        dat_q;
    logic               ack_q, err_q;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    if (SYNC_STAGES == 0) begin : g_nosync
        assign src_sync = irq_src_i;
    end else begin : g_sync
        logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];

        always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
            if (!wb_rst_ni) begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= '0;
                end
            end else begin
                sync_q[0] <= irq_src_i;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign src_sync = sync_q[SYNC_STAGES-1];
    end

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [2:0]         reg_idx;
    logic               req, reg_valid, wr_en;
    logic [31:0]        lane_mask, wr_bits_full;
    logic [NUM_IRQ-1:0] wr_bits, wr_keep;
    logic               wr_pending, wr_mask, wr_mode, wr_pol, wr_swset;
    logic [NUM_IRQ-1:0] w1c, swset;
    logic               unused_adr;

    assign unused_adr = ^wb.wb_adr_i[1:0];

    // A request is only taken while no response is outstanding, so back-to-back
    // strobes are acked every second cycle.
    assign req       = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
    assign reg_idx   = wb.wb_adr_i[4:2];
    assign reg_valid = (reg_idx <= RegSwset);
    assign wr_en     = req & reg_valid & wb.wb_we_i;

    assign lane_mask = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                        {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
    assign wr_bits_full = wb.wb_dat_i & lane_mask;
    assign wr_bits      = wr_bits_full[NUM_IRQ-1:0];
    assign wr_keep      = ~lane_mask[NUM_IRQ-1:0];

    assign wr_pending = wr_en && (reg_idx == RegPending);
    assign wr_mask    = wr_en && (reg_idx == RegMask);
    assign wr_mode    = wr_en && (reg_idx == RegMode);
    assign wr_pol     = wr_en && (reg_idx == RegPolarity);
    assign wr_swset   = wr_en && (reg_idx == RegSwset);

    assign w1c   = wr_pending ? wr_bits : '0;
    assign swset = wr_swset   ? wr_bits : '0;

    // ------------------------------------------------------------------
    // Pending next state
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] edge_evt;
    logic [NUM_IRQ-1:0] edge_next;
    logic [NUM_IRQ-1:0] level_next;

    // Both samples are compared under the current polarity, so a polarity write
    // alone can never look like an edge.
    always_comb begin
        edge_evt   = (src_sync ^ pol_q) & ~(src_d_q ^ pol_q);
        edge_next  = (pending_q & ~w1c) | edge_evt | swset;
        level_next = src_sync ^ pol_q;
        pending_d  = (mode_q & edge_next) | (~mode_q & level_next);
    end

    // ------------------------------------------------------------------
    // Read mux, sampled before any same-edge register update
    // ------------------------------------------------------------------
    logic [31:0] rd_data;

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            RegPending:  rd_data = 32'(pending_q);
            RegMask:     rd_data = 32'(mask_q);
            RegMode:     rd_data = 32'(mode_q);
            RegPolarity: rd_data = 32'(pol_q);
            RegActive:   rd_data = 32'(pending_q & mask_q);
            default:     rd_data = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            src_d_q   <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
            pol_q     <= '0;
        end else begin
            src_d_q   <= src_sync;
            pending_q <= pending_d;
            if (wr_mask) begin
                mask_q <= (mask_q & wr_keep) | wr_bits;
            end
            if (wr_mode) begin
                mode_q <= (mode_q & wr_keep) | wr_bits;
            end
            if (wr_pol) begin
                pol_q <= (pol_q & wr_keep) | wr_bits;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req & reg_valid;
            err_q <= req & ~reg_valid;
            dat_q <= (req & reg_valid & ~wb.wb_we_i) ? rd_data : '0;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = dat_q;

    assign irq_o     = pending_q & mask_q;
    assign irq_any_o = |irq_o;

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Self-checking bench for wb_irq_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model of the register rules.
module tb_wb_irq_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    wb_irq_ctrl_if bus ();
    wb_irq_ctrl_if bus12 ();

    logic [31:0] src;
    logic [31:0] irq;
    logic        irq_any;
    logic [11:0] src12;
    logic [11:0] irq12;
    logic        irq_any12;

    wb_irq_ctrl #(.NUM_IRQ(32), .SYNC_STAGES(2)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wb        (bus.slave),
        .irq_src_i (src),
        .irq_o     (irq),
        .irq_any_o (irq_any)
    );

    wb_irq_ctrl #(.NUM_IRQ(12), .SYNC_STAGES(2)) dut12 (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wb        (bus12.slave),
        .irq_src_i (src12),
        .irq_o     (irq12),
        .irq_any_o (irq_any12)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Behavioural model state
    logic [31:0] m_pend, m_mask, m_mode, m_pol, m_dat;
    logic        m_ack, m_err, m_rd;
    logic [31:0] hist [3];   // source seen at edges k-3, k-2, k-1

    logic [31:0] rd;
    logic        got_ack, got_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h required %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_mode = '0; m_pol = '0; m_dat = '0;
        m_ack = 1'b0; m_err = 1'b0; m_rd = 1'b0;
        for (int i = 0; i < 3; i++) hist[i] = '0;
    endtask

    // One clock edge: advance the model from the inputs present at the edge, then compare.
    task automatic tick();
        logic [31:0] s, sd, bm, wd, w1c, sw, nxt, exp_rd;
        logic        req, hit, edge_seen;
        int          idx;
        @(posedge clk);
        s   = hist[1];
        sd  = hist[0];
        req = bus.wb_cyc_i && bus.wb_stb_i && !m_ack && !m_err;
        idx = int'(bus.wb_adr_i) / 4;
        hit = req && (idx < 6);
        bm  = {{8{bus.wb_sel_i[3]}}, {8{bus.wb_sel_i[2]}}, {8{bus.wb_sel_i[1]}}, {8{bus.wb_sel_i[0]}}};
        wd  = bus.wb_dat_i & bm;
        w1c = '0;
        sw  = '0;
        exp_rd = '0;
        if (hit && !bus.wb_we_i) begin
            case (idx)
                0: exp_rd = m_pend;
                1: exp_rd = m_mask;
                2: exp_rd = m_mode;
                3: exp_rd = m_pol;
                4: exp_rd = m_pend & m_mask;
                default: exp_rd = '0;
            endcase
        end
        if (hit && bus.wb_we_i && idx == 0) w1c = wd;
        if (hit && bus.wb_we_i && idx == 5) sw = wd;
        nxt = m_pend;
        for (int n = 0; n < 32; n++) begin
            if (!m_mode[n]) begin
                nxt[n] = s[n] ^ m_pol[n];
            end else begin
                edge_seen = m_pol[n] ? (!s[n] && sd[n]) : (s[n] && !sd[n]);
                if (edge_seen || sw[n]) nxt[n] = 1'b1;
                else if (w1c[n])        nxt[n] = 1'b0;
            end
        end
        m_pend = nxt;
        if (hit && bus.wb_we_i && idx == 1) m_mask = (m_mask & ~bm) | wd;
        if (hit && bus.wb_we_i && idx == 2) m_mode = (m_mode & ~bm) | wd;
        if (hit && bus.wb_we_i && idx == 3) m_pol  = (m_pol  & ~bm) | wd;
        m_ack = hit;
        m_err = req && (idx >= 6);
        m_rd  = hit && !bus.wb_we_i;
        m_dat = exp_rd;
        hist[0] = hist[1];
        hist[1] = hist[2];
        hist[2] = src;
        #1;
        check("ack", 32'(bus.wb_ack_o), 32'(m_ack));
        check("err", 32'(bus.wb_err_o), 32'(m_err));
        if (m_rd) check("rdata", bus.wb_dat_o, m_dat);
        check("irq_o", irq, m_pend & m_mask);
        check("irq_any", 32'(irq_any), 32'(|(m_pend & m_mask)));
    endtask

    task automatic bus_req(input logic [4:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat,
                           output logic ack, output logic err);
        bus.wb_adr_i = adr; bus.wb_we_i = we; bus.wb_dat_i = dat; bus.wb_sel_i = sel;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        tick();
        rdat = bus.wb_dat_o; ack = bus.wb_ack_o; err = bus.wb_err_o;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] r;
        logic        a, e;
        bus_req(adr, 1'b1, dat, sel, r, a, e);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] adr, input logic [31:0] msk,
                          input logic [31:0] exp);
        logic [31:0] r;
        logic        a, e;
        bus_req(adr, 1'b0, '0, 4'hF, r, a, e);
        check(tag, r & msk, exp);
    endtask

    task automatic bus12_req(input logic [4:0] adr, input logic we, input logic [31:0] dat,
                             input logic [3:0] sel, output logic [31:0] rdat, output logic ack);
        bus12.wb_adr_i = adr; bus12.wb_we_i = we; bus12.wb_dat_i = dat; bus12.wb_sel_i = sel;
        bus12.wb_cyc_i = 1'b1; bus12.wb_stb_i = 1'b1;
        tick();
        rdat = bus12.wb_dat_o; ack = bus12.wb_ack_o;
        bus12.wb_cyc_i = 1'b0; bus12.wb_stb_i = 1'b0; bus12.wb_we_i = 1'b0;
        tick();
    endtask

    initial begin
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
        bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        bus12.wb_adr_i = '0; bus12.wb_dat_i = '0; bus12.wb_sel_i = '0;
        bus12.wb_we_i = 1'b0; bus12.wb_cyc_i = 1'b0; bus12.wb_stb_i = 1'b0;
        src = '0;
        src12 = '0;
        model_reset();

        #1 rst_n = 1'b0;
        #2;
        check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
        check("rst_irq", irq, 32'd0);
        check("rst_any", 32'(irq_any), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset values of all six registers
        for (int a = 0; a < 6; a++) rd_chk("reset_reg", 5'(a * 4), '1, 32'd0);

        // Edge latency with two synchroniser stages
        wr(5'h08, 32'h4, 4'hF);
        wr(5'h04, 32'h4, 4'hF);
        src[2] = 1'b1;
        tick(); check("lat_c1", 32'(irq[2]), 32'd0);
        tick(); check("lat_c2", 32'(irq[2]), 32'd0);
        tick(); check("lat_c3", 32'(irq[2]), 32'd1);
        rd_chk("edge_pend", 5'h00, '1, 32'h4);
        wr(5'h00, 32'h4, 4'hF);
        check("w1c_irq", 32'(irq[2]), 32'd0);
        repeat (3) tick();
        rd_chk("no_retrig", 5'h00, '1, 32'h0);

        // Level mode with inverted polarity
        wr(5'h0C, 32'h1, 4'hF);
        wr(5'h04, 32'h1, 4'hF);
        check("lvl_low", 32'(irq[0]), 32'd1);
        wr(5'h00, 32'h1, 4'hF);
        check("lvl_w1c", 32'(irq[0]), 32'd1);
        src[0] = 1'b1;
        tick(); check("lvl_c1", 32'(irq[0]), 32'd1);
        tick(); check("lvl_c2", 32'(irq[0]), 32'd1);
        tick(); check("lvl_c3", 32'(irq[0]), 32'd0);

        // Set wins over a same-edge W1C
        wr(5'h08, 32'h20, 4'hF);
        wr(5'h04, 32'h20, 4'hF);
        src[5] = 1'b1;
        tick();
        tick();
        bus.wb_adr_i = 5'h00; bus.wb_we_i = 1'b1; bus.wb_dat_i = 32'h20; bus.wb_sel_i = 4'hF;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        tick();
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        tick();
        rd_chk("set_wins", 5'h00, 32'h20, 32'h20);
        wr(5'h08, 32'h0, 4'hF);
        src[5] = 1'b0;
        repeat (3) tick();
        wr(5'h14, 32'h20, 4'hF);
        rd_chk("swset_lvl", 5'h00, 32'h20, 32'h0);
        rd_chk("swset_rd0", 5'h14, '1, 32'h0);

        // Byte lanes and unimplemented offsets
        wr(5'h04, 32'h0, 4'hF);
        wr(5'h04, 32'hFFFF_FFFF, 4'h2);
        rd_chk("lane_mask", 5'h04, '1, 32'h0000_FF00);
        bus_req(5'h18, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, got_ack, got_err);
        check("err18_err", 32'(got_err), 32'd1);
        check("err18_ack", 32'(got_ack), 32'd0);
        bus_req(5'h1D, 1'b0, '0, 4'hF, rd, got_ack, got_err);
        check("err1c_err", 32'(got_err), 32'd1);
        rd_chk("err_nochg", 5'h04, '1, 32'h0000_FF00);

        // Narrow instance: bits at and above NUM_IRQ read 0
        bus12_req(5'h04, 1'b1, 32'hFFFF_FFFF, 4'h2, rd, got_ack);
        check("n12_wack", 32'(got_ack), 32'd1);
        bus12_req(5'h04, 1'b0, '0, 4'hF, rd, got_ack);
        check("n12_mask", rd, 32'h0000_0F00);
        bus12_req(5'h0C, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, got_ack);
        bus12_req(5'h0C, 1'b0, '0, 4'hF, rd, got_ack);
        check("n12_pol", rd, 32'h0000_0FFF);

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            src = src ^ ($urandom & $urandom & $urandom);
            case ($urandom_range(0, 3))
                0: tick();
                1: wr(5'($urandom_range(0, 31)), $urandom, 4'($urandom));
                default: bus_req(5'($urandom_range(0, 31)), 1'b0, '0, 4'hF, rd, got_ack, got_err);
            endcase
        end

        // Asynchronous reset in the middle of an acked write with an interrupt active
        src = '0;
        repeat (4) tick();
        wr(5'h0C, 32'h0, 4'hF);
        wr(5'h08, 32'h80, 4'hF);
        wr(5'h04, 32'h80, 4'hF);
        wr(5'h14, 32'h80, 4'hF);
        check("pre_rst_any", 32'(irq_any), 32'd1);
        bus.wb_adr_i = 5'h04; bus.wb_we_i = 1'b1; bus.wb_dat_i = 32'hFFFF_FFFF; bus.wb_sel_i = 4'hF;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ack", 32'(bus.wb_ack_o), 32'd0);
        check("mid_rst_err", 32'(bus.wb_err_o), 32'd0);
        check("mid_rst_dat", bus.wb_dat_o, 32'd0);
        check("mid_rst_irq", irq, 32'd0);
        check("mid_rst_any", 32'(irq_any), 32'd0);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_chk("post_rst_mask", 5'h04, '1, 32'h0);
        rd_chk("post_rst_pend", 5'h00, '1, 32'h0);
        check("post_rst_any", 32'(irq_any), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_irq_ctrl.md
# wb_irq_ctrl

Parametrised Wishbone interrupt controller that collects up to 32 peripheral interrupt lines and drives the mor1kx `irq_i` vector. It replaces the hard-wired interrupt assignment in the SoC top. Each channel has:
- a synchroniser,
- programmable level/edge mode and polarity,
- a sticky pending bit,
- a mask bit.

A Wishbone B3 classic slave on the interconnect exposes pending, mask, mode, polarity and software-set registers.

## Interface
Parameters:
- NUM_IRQ, 32, number of interrupt channels, legal range 1..32.
- SYNC_STAGES, 2, synchroniser flops per input, legal range 0..3; 0 means the inputs are already synchronous to wb_clk_i.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- wb_adr_i  in  5  byte address; bits [4:2] select the register, bits [1:0] are ignored.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte-lane write enables.
- wb_we_i  in  1  write strobe qualifier.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  32  read data, valid while wb_ack_o is high.
- wb_ack_o  out  1  transfer acknowledge.
- wb_err_o  out  1  access to an unimplemented offset.
- irq_src_i  in  NUM_IRQ  raw interrupt sources; may be asynchronous.
- irq_o  out  NUM_IRQ  active interrupts (PENDING & MASK) to the CPU.
- irq_any_o  out  1  OR-reduction of irq_o.

## Operation
Registers (byte offset, access, reset value):
- 0x00 PENDING, R / W1C, 0.
- 0x04 MASK, RW, 0 (all channels masked).
- 0x08 MODE, RW, 0; bit=1 edge, bit=0 level.
- 0x0C POLARITY, RW, 0; bit=1 active-low / falling edge.
- 0x10 ACTIVE, RO, PENDING & MASK.
- 0x14 SWSET, WO, reads 0; writing 1 sets PENDING for edge-mode channels and has no effect on level-mode channels.
- Offsets 0x18–0x1C return wb_err_o instead of wb_ack_o, with no side effects.

Bit and write rules:
- Bits at index NUM_IRQ and above read 0 and ignore writes.
- Writes honour wb_sel_i per byte lane; unselected lanes keep their value and do not clear PENDING.

Per-channel behaviour, where s = synchronised source:
- Level mode: PENDING[n] <= s ^ POLARITY[n] every cycle. W1C and SWSET have no effect.
- Edge mode: a registered copy s_d detects edges on the raw synchronised value.
  - rise = s & ~s_d; fall = ~s & s_d.
  - PENDING[n] sets on (POLARITY ? fall : rise).
  - A polarity change alone never creates an edge.
  - PENDING[n] is sticky until cleared by W1C.
- Simultaneous edge (or SWSET) and W1C on the same bit in the same cycle: set wins and PENDING stays 1.
- Mode change from edge to level: PENDING tracks the level from the next cycle.
- Mode change from level to edge: PENDING holds its current value until W1C.
- MASK does not gate PENDING; masked channels still latch.

Wishbone handshake:
- A request (wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o) registers wb_ack_o or wb_err_o high for exactly one cycle.
- Register writes take effect on the same edge that raises ack.
- Read data is captured on that edge.
- Back-to-back requests give ack on every second cycle.
- wb_cyc_i dropping while ack is high causes no side effect.

## Timing
- Every output is 0 during reset. Reset assertion is immediate (asynchronous) and clears all flops, including the synchronisers and s_d. Removal is synchronous to wb_clk_i and must be synchronised externally.
- Source-to-irq_o latency is SYNC_STAGES+1 cycles from the first clock edge at which the source meets setup. irq_o and irq_any_o are combinational from the PENDING and MASK flops.
- After a W1C of a bit whose edge source is quiet, irq_o falls on the same edge as wb_ack_o.
- A MASK write changes irq_o on the ack edge.
- A read of PENDING returns the value before any same-edge update.
- Pulses shorter than one wb_clk_i period may be missed; this is a documented limitation.
- Reset asserted mid-transfer drops wb_ack_o and wb_err_o immediately, and no write is committed.

## Test plan
- Reset values: release reset, read all six offsets -> 0x0 each; irq_o=0; irq_any_o=0.
- Edge latency (SYNC_STAGES=2): set MODE=0x4 and MASK=0x4, raise irq_src_i[2] -> PENDING=0x4 and irq_o[2]=1 exactly 3 cycles later. Hold the source high, W1C 0x4 -> PENDING=0, with no re-trigger.
- Level and polarity: set POLARITY=0x1 and MASK=0x1, drive irq_src_i[0]=0 -> irq_o[0]=1. W1C 0x1 -> still 1. Drive the source to 1 -> irq_o[0]=0 after 3 cycles.
- Set-wins collision: edge on channel 5 landing on the same edge as W1C 0x20 -> PENDING[5]=1. SWSET 0x20 on a level-mode channel -> no change.
- Byte lanes and bus errors:
  - MASK write 0xFFFFFFFF with sel=0x2 -> MASK=0x0000FF00.
  - NUM_IRQ=12 -> MASK reads 0x00000F00.
  - Access to 0x18 -> wb_err_o for one cycle, no ack, registers unchanged.
- Async reset mid-operation: assert wb_rst_ni low while a write is being acked and with PENDING nonzero -> all outputs 0 without waiting for a clock edge, and the write is not committed after release.
